// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 32'hFC00_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fold a byte address into the instruction-memory window.
    function automatic logic [INSTR_W-1:0] wrap_pc(input logic [INSTR_W-1:0] addr,
                                                   input logic [INSTR_W-1:0] span);
        return addr % span;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a registered head
// that keeps its last value while the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head_q, head_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d, after_pop_s;
    logic          do_pop_s, do_push_s;

    // Pointer, occupancy and next-head computation.
    always_comb begin
        do_pop_s    = pop_i && (count_q != '0);
        do_push_s   = push_i && ((count_q != FULL_CNT) || do_pop_s);
        after_pop_s = count_q - (PW+1)'(do_pop_s);
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        head_d      = head_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            count_d = after_pop_s + (PW+1)'(do_push_s);
            // A push into a queue that drains to empty becomes the head directly.
            if (count_d != '0) begin
                if (after_pop_s != '0) begin
                    head_d = mem_q[rd_ptr_d];
                end else begin
                    head_d = push_data_i;
                end
            end else begin
                head_d = head_q;
            end
        end
    end

    // Queue storage and control registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s && !flush_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            head_q   <= head_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC ownership, redirects, wrap-around and halt.
// Optional macro FETCH_PERF_CNT_EN adds fetch/stall/flush counters.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned        DEPTH     = 2,
    parameter int unsigned        MEM_WORDS = 16,
    parameter logic [INSTR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   start,
    output logic [INSTR_W-1:0]     pc,
    output logic                   InsMemRW,
    input  logic [INSTR_W-1:0]     imem_instr,
    input  logic                   redirect_valid,
    input  logic [INSTR_W-1:0]     redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_W-1:0]     instr_data,
    output logic [INSTR_W-1:0]     instr_pc,
    output logic                   halted,
    output logic                   misalign,
    output logic [$clog2(DEPTH):0] q_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_cnt,
    output logic [31:0]            stall_cnt,
    output logic [15:0]            flush_cnt
`endif
);

    localparam int unsigned QW = $clog2(DEPTH) + 1;
    localparam logic [INSTR_W-1:0] PC_SPAN = INSTR_W'(MEM_WORDS * 4);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               misalign_q, misalign_d;
    logic               pop_s, redirect_s, fetch_en_s, is_halt_s, full_s;
    logic [QW-1:0]      q_count_s;
    fetch_entry_t       head_s;

    assign is_halt_s = (imem_instr == HALT_WORD);
    assign full_s    = (q_count_s == QW'(DEPTH));

    // FSM state register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a redirect always wins over halt detection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
                else       state_d = IDLE;
            end
            FETCH: begin
                if (redirect_valid)               state_d = FETCH;
                else if (fetch_en_s && is_halt_s) state_d = HALTED;
                else                              state_d = FETCH;
            end
            HALTED: begin
                if (redirect_valid) state_d = FETCH;
                else                state_d = HALTED;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and handshake qualifiers.
    always_comb begin
        pop_s      = instr_valid && instr_ready;
        redirect_s = redirect_valid && (state_q != IDLE);
        fetch_en_s = (state_q == FETCH) && (!full_s || pop_s) && !redirect_valid;
        InsMemRW   = fetch_en_s;
        halted     = (state_q == HALTED);
    end

    // PC and sticky misalignment next-state; pc parks on the halt word.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redirect_s) begin
            pc_d       = wrap_pc({redirect_pc[INSTR_W-1:2], 2'b00}, PC_SPAN);
            misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
        end else if (fetch_en_s && !is_halt_s) begin
            pc_d = wrap_pc(pc_q + 32'd4, PC_SPAN);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and misalignment registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i       (CLK),
        .rst_ni      (Reset),
        .push_i      (fetch_en_s),
        .push_data_i ('{pc: pc_q, instr: imem_instr}),
        .pop_i       (pop_s),
        .flush_i     (redirect_s),
        .valid_o     (instr_valid),
        .head_o      (head_s),
        .count_o     (q_count_s)
    );

    assign pc         = pc_q;
    assign misalign   = misalign_q;
    assign q_count    = q_count_s;
    assign instr_data = head_s.instr;
    assign instr_pc   = head_s.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Free-running performance counters; they wrap on overflow.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (fetch_en_s) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if ((state_q == FETCH) && full_s && !pop_s) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect_s) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a queue-based reference model.
module tb_fetch_controller;

    localparam int          DEPTH     = 2;
    localparam int          MEM_WORDS = 16;
    localparam logic [31:0] HALT      = 32'hFC00_0000;

    logic        CLK = 1'b0;
    logic        Reset, start, InsMemRW, redirect_valid, instr_valid, instr_ready;
    logic        halted, misalign;
    logic [31:0] pc, imem_instr, redirect_pc, instr_data, instr_pc;
    logic [1:0]  q_count;
    logic [31:0] mem [MEM_WORDS];
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
    logic [15:0] flush_cnt;
    int unsigned m_fc, m_sc, m_flc;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    ent_t        last_e;
    bit          m_started, m_stopped, m_mis;
    logic [31:0] m_pc;
    int          n_cmp, n_bad;

    always #5 CLK = ~CLK;
    assign imem_instr = mem[pc[5:2]];

    fetch_controller dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .start          (start),
        .pc             (pc),
        .InsMemRW       (InsMemRW),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .halted         (halted),
        .misalign       (misalign),
        .q_count        (q_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        last_e    = '{32'h0, 32'h0};
        m_started = 1'b0;
        m_stopped = 1'b0;
        m_mis     = 1'b0;
        m_pc      = 32'h0;
`ifdef FETCH_PERF_CNT_EN
        m_fc = 0; m_sc = 0; m_flc = 0;
`endif
    endtask

    // Compare this cycle's outputs with the model, then advance the model one clock.
    task automatic check_and_advance();
        bit   pop, acc, fe;
        ent_t e;
        pop = (mq.size() > 0) && instr_ready;
        acc = redirect_valid && m_started;
        fe  = m_started && !m_stopped && ((mq.size() < DEPTH) || pop) && !redirect_valid;
        e   = (mq.size() > 0) ? mq[0] : last_e;
        chk("pc", pc, m_pc);
        chk("InsMemRW", 32'(InsMemRW), 32'(fe));
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        chk("instr_pc", instr_pc, e.pc);
        chk("instr_data", instr_data, e.instr);
        chk("halted", 32'(halted), 32'(m_stopped));
        chk("misalign", 32'(misalign), 32'(m_mis));
        chk("q_count", 32'(q_count), 32'(mq.size()));
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, 32'(m_fc));
        chk("stall_cnt", stall_cnt, 32'(m_sc));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flc & 16'hFFFF));
        if (fe) m_fc++;
        if (m_started && !m_stopped && mq.size() == DEPTH && !pop) m_sc++;
        if (acc) m_flc++;
`endif
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.delete();
            m_pc      = {redirect_pc[31:2], 2'b00} % (MEM_WORDS * 4);
            m_stopped = 1'b0;
            if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
        end else if (fe) begin
            e.pc    = m_pc;
            e.instr = mem[m_pc >> 2];
            mq.push_back(e);
            if (e.instr == HALT) m_stopped = 1'b1;
            else                 m_pc = (m_pc + 32'd4) % (MEM_WORDS * 4);
        end
        if (start) m_started = 1'b1;
        if (mq.size() > 0) last_e = mq[0];
    endtask

    // One clock: called at posedge+1, samples at the falling edge.
    task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rpc, input bit st);
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        start          = st;
        #4;
        check_and_advance();
        @(posedge CLK);
        #1;
        start          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0000_0013 + 32'(i << 7);
        mem[1]  = 32'h0080_8113;
        mem[12] = HALT;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        n_cmp = 0; n_bad = 0;
        Reset = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        load_program();
        model_reset();
        @(posedge CLK); #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_qcount", 32'(q_count), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_rw", 32'(InsMemRW), 32'h0);
        @(posedge CLK); #1;
        Reset = 1'b1;

        // Start, sequential fetch, then back-pressure.
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_qcount", 32'(q_count), 32'h2);
        chk("stall_pc", pc, 32'h10);
        chk("stall_rw", 32'(InsMemRW), 32'h0);
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_redir_qcount", 32'(q_count), 32'h2);
        cyc(1'b0, 1'b1, 32'h14, 1'b0);
        chk("redir_qcount", 32'(q_count), 32'h0);
        chk("redir_pc", pc, 32'h14);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("redir_head_pc", instr_pc, 32'h14);

        // Run into the halt word at 0x30.
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            seen = halted;
        end
        chk("halt_seen", 32'(seen), 32'h1);
        chk("halt_pc", pc, 32'h30);
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("halt_hold_pc", pc, 32'h30);
        chk("halt_drained", 32'(q_count), 32'h0);
        cyc(1'b1, 1'b1, 32'h0, 1'b0);
        chk("unhalt", 32'(halted), 32'h0);
        chk("unhalt_pc", pc, 32'h0);

        // Wrap-around and misaligned target.
        cyc(1'b0, 1'b1, 32'h3C, 1'b0);
        chk("wrap_target", pc, 32'h3C);
        repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_head", instr_pc, 32'h3C);
        chk("wrap_pc", pc, 32'h4);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_second", instr_pc, 32'h0);
        cyc(1'b1, 1'b1, 32'h0A, 1'b0);
        chk("misalign_pc", pc, 32'h08);
        chk("misalign_set", 32'(misalign), 32'h1);
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("misalign_sticky", 32'(misalign), 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                for (int j = 0; j < MEM_WORDS; j++)
                    mem[j] = ($urandom_range(0, 7) == 0) ? HALT : ($urandom & 32'h03FF_FFFF);
            end
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                $urandom & 32'h0000_007F, $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset with a full queue.
        load_program();
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("prereset_full", 32'(q_count), 32'h2);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_qcount", 32'(q_count), 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_halted", 32'(halted), 32'h0);
        chk("arst_misalign", 32'(misalign), 32'h0);
        chk("arst_rw", 32'(InsMemRW), 32'h0);
        model_reset();
        @(posedge CLK); #1;
        Reset = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("idle_no_fetch", 32'(q_count), 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch from the 16-word, combinationally-read instruction memory.
- Owns the PC and drives it to the memory.
- Captures each fetched word with its PC into a small queue and presents it to decode over a valid/ready handshake.
- Handles branch/jump redirects, PC wrap-around and halt detection.
- Sits between the instruction memory and the decode/control stage of the CPU.

Parameters:
- DEPTH, 2, fetch queue entries (power of two, ≥2).
- MEM_WORDS, 16, instruction-memory words; the PC wraps modulo MEM_WORDS*4.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- HALT_WORD, 32'hFC00_0000, instruction encoding that stops fetch.

Ports:
- CLK, in, 1: system clock, rising edge.
- Reset, in, 1: asynchronous, active-low reset.
- start, in, 1: single-cycle pulse; leaves IDLE.
- pc, out, 32: fetch address to the instruction memory.
- InsMemRW, out, 1: instruction-memory read enable; 1 in cycles where a fetch is enqueued.
- imem_instr, in, 32: combinational instruction word for the current pc.
- redirect_valid, in, 1: branch/jump taken this cycle.
- redirect_pc, in, 32: redirect target.
- instr_valid, out, 1: queue head valid.
- instr_ready, in, 1: decode accepts the head.
- instr_data, out, 32: head instruction word.
- instr_pc, out, 32: PC of the head instruction.
- halted, out, 1: HALT_WORD has been fetched and fetch is stopped.
- misalign, out, 1: sticky flag; set when a redirect target has bit[1:0] ≠ 0.
- q_count, out, $clog2(DEPTH)+1: current queue occupancy.

Behaviour:
- Reset (asynchronous, any state or mid-operation):
  - pc=RESET_PC, state=IDLE, queue emptied, q_count=0.
  - instr_valid=0, halted=0, misalign=0, InsMemRW=0.
- States and transitions:
  - IDLE → FETCH on start.
  - FETCH → HALTED when HALT_WORD is enqueued.
  - HALTED → FETCH on redirect_valid.
  - IDLE ignores redirect_valid.
- pop = instr_valid & instr_ready.
- fetch_en = (state==FETCH) & (q_count<DEPTH | pop) & ~redirect_valid. InsMemRW = fetch_en, combinational.
- On fetch_en:
  - Enqueue {pc, imem_instr}.
  - pc ← (pc+4) mod (MEM_WORDS*4). Word MEM_WORDS-1 is followed by word 0.
- Latency: a word fetched in cycle N is visible at instr_valid/instr_data in cycle N+1. Queue output is registered, FIFO order.
- Full queue with no pop: hold pc; InsMemRW=0.
- Full queue with pop: enqueue and dequeue in the same cycle; q_count is unchanged.
- Empty queue: instr_valid=0; instr_data/instr_pc hold their last value.
- Halt:
  - If imem_instr==HALT_WORD on a fetch_en cycle, the word is enqueued and delivered normally.
  - Next state is HALTED and halted=1 from the next cycle.
  - pc holds the halt address; no further fetch.
  - The queue keeps draining while HALTED.
- Redirect (highest priority, FETCH or HALTED):
  - Queue flushed next cycle, q_count=0.
  - pc ← {redirect_pc[31:2],2'b00} mod (MEM_WORDS*4).
  - halted←0, state=FETCH.
  - No enqueue in the redirect cycle. First fetch from the target occurs in the cycle after.
  - A pop in the same cycle as a redirect still counts as transferred.
- Misalignment: misalign is set when redirect_pc[1:0]≠0. It clears only on reset.
- A start pulse outside IDLE is ignored.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0], stall_cnt[31:0] and flush_cnt[15:0], all reset to 0 and wrapping on overflow.
  - fetch_cnt increments on each fetch_en.
  - stall_cnt increments on FETCH cycles with a full queue and no pop.
  - flush_cnt increments on each accepted redirect.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - State enum fetch_state_t {IDLE, FETCH, HALTED}.
  - HALT_WORD default and INSTR_W=32.
  - Entry struct fetch_entry_t {pc, instr}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push/pop/flush/count, instantiated once.
- The FSM and PC logic stay in fetch_controller.

Test Plan:
- Reset low, start at cycle 2, instr_ready=1, memory word1=32'h00808113 → pc sequence 0,4,8,…; instr_pc=4 with instr_data=32'h00808113 one cycle after pc=4.
- instr_ready=0 for 5 cycles → q_count reaches 2, pc frozen, InsMemRW=0; release ready → entries delivered in order with no loss or duplication.
- Redirect to 32'h14 with q_count=2 → next cycle q_count=0 and pc=32'h14; the next delivered instr_pc is 32'h14.
- Word12=32'hFC000000 reached sequentially → delivered with instr_pc=32'h30; halted=1, pc stays 32'h30; redirect to 0 → halted=0 and fetch resumes at 0.
- Redirect to 32'h3C, then fetch 2 words → instr_pc 32'h3C then 32'h00 (wrap). Redirect to 32'h0A → pc=32'h08, misalign=1 and sticky.
- Reset asserted mid-fetch with the queue full → same cycle: instr_valid=0, q_count=0, pc=0, state IDLE; no fetch until a new start.
